// File: rtl/corelet_seq.sv
// corelet_seq: drives the corelet 34-bit instruction bus through one weight-stationary tile pass.
// Optional drain watchdog is enabled by defining CORELET_SEQ_WDOG_EN.
module corelet_seq #(
    parameter int row = 8,
    parameter int col = 8,
    parameter int aw  = 8,
    parameter int tmo = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [aw-1:0] n_act,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          l0_o_full,
    input  logic          ofifo_valid,
    output logic [33:0]   inst,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int GW = $clog2(row + col + 1);
    localparam int CW = (aw > GW) ? aw : GW;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] COL_LAST = CW'(col - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(row + col - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_K_WR,
        S_K_LD,
        S_K_GAP,
        S_A_WR,
        S_A_EX,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rdcnt_q, rdcnt_d;
    logic [aw-1:0] act_n_q, act_n_d;
    logic          acc_q, acc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [CW-1:0] act_cw, act_last;
    logic          wr_en, rd_en, drain_end, wdog_fire;

    assign act_cw    = CW'(act_n_q);
    assign act_last  = act_cw - ONE;
    assign wr_en     = ((state_q == S_K_WR) || (state_q == S_A_WR)) && in_valid && !l0_o_full;
    // Reads stop once all rows are taken so the exit cycle never issues a stray read
    assign rd_en     = (state_q == S_DRAIN) && ofifo_valid && (rdcnt_q != act_cw);
    assign drain_end = (rdcnt_q == act_cw);

    always_comb begin
        inst     = '0;
        inst[0]  = (state_q == S_K_LD);
        inst[1]  = (state_q == S_A_EX);
        inst[2]  = wr_en;
        inst[3]  = (state_q == S_K_LD) || (state_q == S_A_EX);
        inst[6]  = rd_en;
        inst[33] = acc_q;
    end

    assign in_ready = wr_en;
    assign busy     = busy_q;
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdcnt_d = rdcnt_q;
        act_n_d = act_n_q;
        acc_d   = rd_en;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    act_n_d = n_act;
                    cnt_d   = '0;
                    rdcnt_d = '0;
                    state_d = S_K_WR;
                end
            end
            S_K_WR: begin
                if (wr_en) begin
                    if (cnt_q == COL_LAST) begin
                        cnt_d   = '0;
                        state_d = S_K_LD;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            S_K_LD: begin
                if (cnt_q == COL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_K_GAP;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_K_GAP: begin
                // Weights need row+col cycles to settle through the array
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (act_n_q == '0) ? S_DONE : S_A_WR;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_A_WR: begin
                if (wr_en) begin
                    if (cnt_q == act_last) begin
                        cnt_d   = '0;
                        state_d = S_A_EX;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            S_A_EX: begin
                if (cnt_q == act_last) begin
                    cnt_d   = '0;
                    rdcnt_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DRAIN: begin
                // drain_end is first true in the cycle carrying the last acc pulse
                if (drain_end) begin
                    state_d = S_DONE;
                end else begin
                    if (rd_en) begin
                        rdcnt_d = rdcnt_q + ONE;
                    end
                    if (wdog_fire) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdcnt_q <= '0;
            act_n_q <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdcnt_q <= rdcnt_d;
            act_n_q <= act_n_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CORELET_SEQ_WDOG_EN
    localparam int TW = $clog2(tmo + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(tmo - 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          err_q, err_d;

    always_comb begin
        idle_d    = '0;
        err_d     = err_q;
        wdog_fire = 1'b0;
        if ((state_q == S_DRAIN) && !drain_end) begin
            if (ofifo_valid) begin
                idle_d = '0;
            end else if (idle_q == TMO_LAST) begin
                wdog_fire = 1'b1;
                err_d     = 1'b1;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (tmo != 0);
    assign wdog_fire  = 1'b0;
    assign err        = 1'b0;
`endif

endmodule

// File: doc/corelet_seq.md
Name: corelet_seq

Overview:
- Sequencer that drives the corelet 34-bit instruction bus for one weight-stationary tile pass.
- Tile pass order: kernel write into L0, kernel load into the MAC array, a settle gap, activation write into L0, execute, then OFIFO drain with SFP accumulate.
- Sits between the top-level tile scheduler (start/done, data-valid handshake) and one corelet instance.

Parameters:
- row, 8, MAC array rows / L0 lanes
- col, 8, MAC array columns; number of kernel vectors per tile
- aw, 8, width of activation-count field (max 2^aw-1 vectors)
- tmo, 255, drain watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin tile pass; sampled only in IDLE
- n_act  in  aw  number of activation vectors; latched when start is accepted
- in_valid  in  1  upstream data word valid for L0
- in_ready  out  1  word consumed this cycle (equals inst[2])
- l0_o_full  in  1  L0 full
- ofifo_valid  in  1  OFIFO holds a complete output row
- inst  out  34  corelet instruction bus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the pass completes
- err  out  1  sticky watchdog error (optional feature only; otherwise tied 0)

Behaviour:
- Reset: state=IDLE; all counters 0; inst=0, in_ready=0, busy=0, done=0, err=0. Reset asserted mid-pass aborts immediately; no further inst bits are issued.
- inst bit map: [0] kernel load; [1] execute; [2] L0 wr; [3] L0 rd; [6] OFIFO rd; [33] SFP acc. All other bits are always 0.
- Output timing: inst is decoded from registered state/counters, with two exceptions:
  - inst[2] is additionally gated by in_valid & !l0_o_full.
  - inst[6] is additionally gated by ofifo_valid.
- inst[33] is a registered copy of inst[6], so the acc pulse lands one cycle after each OFIFO read.
- IDLE: inst=0. start=1 latches n_act into act_n, clears counters and moves to K_WR. start while busy is ignored.
- K_WR: inst[2]=in_valid&!l0_o_full; cnt increments on each write. After the col-th write, go to K_LD with cnt=0.
- K_LD: inst[3]=1, inst[0]=1 for exactly col cycles, then go to K_GAP.
- K_GAP: inst=0 for row+col cycles (weights propagate through the array).
  - act_n==0: go to DONE.
  - otherwise: go to A_WR.
- A_WR: same handshake as K_WR; after act_n writes, go to A_EX.
- A_EX: inst[3]=1, inst[1]=1 for act_n cycles, then go to DRAIN with rdcnt=0.
- DRAIN: inst[6]=ofifo_valid; rdcnt increments per read. When rdcnt reaches act_n and the final delayed inst[33] has issued, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. busy deasserts in IDLE.
- Stall rules:
  - in_valid=0 or l0_o_full=1 in a WR state: hold state, no write, counter unchanged.
  - ofifo_valid low in DRAIN: wait indefinitely (unless the optional feature is enabled).
- Counters are width max(aw, clog2(row+col+1)). No wrap-around is reachable because phases exit on exact compare.

Optional Feature:
- Macro: CORELET_SEQ_WDOG_EN.
- Defined:
  - An idle counter in DRAIN increments on cycles with ofifo_valid=0 and clears on each read.
  - When the counter reaches tmo: err sets (sticky until reset), FSM goes to DONE, and done pulses.
- Not defined: no counter is built, err is tied 0, and DRAIN waits indefinitely.

Test Plan:
- Nominal pass: reset; start with n_act=4, in_valid held 1 -> 8 inst[2] pulses; 8 cycles of inst[3]&inst[0]; 16 idle cycles; 4 inst[2]; 4 cycles of inst[3]&inst[1]; then with ofifo_valid=1, 4 inst[6] each followed next cycle by inst[33]; done pulses once; busy falls the cycle after done.
- Backpressure: l0_o_full=1 for 3 cycles during K_WR write #5 -> no inst[2] and in_ready=0 during those cycles; exactly 8 writes still total; timing otherwise shifts by 3 cycles.
- Zero activations: start with n_act=0 -> K phases only, no inst[1]/inst[6], done immediately after the 16-cycle gap.
- Reset mid-pass: assert reset on the 2nd cycle of A_EX -> the next cycle shows inst=0, busy=0; a new start then runs a full pass normally.
- Start during busy: pulse start in K_LD with n_act=7 -> ignored; the pass completes using the originally latched value.
- Watchdog (CORELET_SEQ_WDOG_EN, tmo=10): hold ofifo_valid=0 in DRAIN -> err=1 and a done pulse after 10 cycles; err stays 1 until reset.
